// File: rtl/axi_helper.sv
// Shared AXI4 types for the burst memory subordinate.
// Response codes, burst kinds and FSM state encodings.
package axi_helper;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address and beat legality for one AXI channel.
// In: addr, len, burst. Out: next_addr, burst_err. WRAP support: SUBMEM_WRAP_EN.
module axi_burst_addr
    import axi_helper::*;
#(
    parameter int ADDR_W = 32,
    parameter int NB     = 4,
    parameter int AW     = 12
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              burst_err
);

`ifdef SUBMEM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LANE = ADDR_W'(NB - 1);

    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_next;
    logic              range_err;
    logic              is_wrap;

    assign aligned = addr & ~LANE;
    assign incr    = aligned + ADDR_W'(NB);
    assign is_wrap = (burst_t'(burst) == WRAP);

    if (ADDR_W > AW) begin : g_range
        assign range_err = |addr[ADDR_W-1:AW];
    end else begin : g_norange
        assign range_err = 1'b0;
    end

`ifdef SUBMEM_WRAP_EN
    logic [ADDR_W-1:0] wmask;
    assign wmask = ((ADDR_W'(len) + ADDR_W'(1)) * ADDR_W'(NB))
                 - ADDR_W'(1);
    assign wrap_next = (addr & ~wmask) | (incr & wmask);
`else
    // Every WRAP beat is an error here, so its address is irrelevant.
    assign wrap_next = incr;
`endif

    always_comb begin
        next_addr = addr;
        unique case (burst_t'(burst))
            FIXED:   next_addr = addr;
            INCR:    next_addr = incr;
            WRAP:    next_addr = wrap_next;
            default: next_addr = addr;
        endcase
    end

    assign burst_err = range_err
                     | (burst_t'(burst) == RSVD)
                     | (is_wrap & (~wrap_len_ok(len) | ~WRAP_EN));

endmodule

// File: rtl/axi4_sub_burst_mem.sv
// AXI4 subordinate with byte-addressed memory; FIXED/INCR/WRAP bursts, SLVERR.
// Ports: AW/W/B write channels, AR/R read channels, ACLK, ARESETn. WRAP: SUBMEM_WRAP_EN.
module axi4_sub_burst_mem
    import axi_helper::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(MEM_BYTES);
    localparam int LW = $clog2(NB);

    logic [7:0] mem [MEM_BYTES];

    wr_state_t         wr_state;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_len;
    logic [1:0]        wr_burst;
    logic [7:0]        wr_cnt;
    logic              wr_err;
    logic [ADDR_W-1:0] wr_next;
    logic              wr_beat_err;
    logic              w_fire;
    logic              w_last;
    logic              w_bad;
    logic [AW-1:0]     wr_idx;

    axi_burst_addr #(.ADDR_W(ADDR_W), .NB(NB), .AW(AW)) u_wr_addr (
        .addr      (wr_addr),
        .len       (wr_len),
        .burst     (wr_burst),
        .next_addr (wr_next),
        .burst_err (wr_beat_err)
    );

    assign w_fire = (wr_state == W_DATA) && WVALID && WREADY;
    assign w_last = (wr_cnt == wr_len);
    assign w_bad  = wr_beat_err | (WLAST != w_last);
    assign wr_idx = {wr_addr[AW-1:LW], {LW{1'b0}}};

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_state <= W_IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BRESP    <= OKAY;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_burst <= '0;
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
        end else begin
            unique case (wr_state)
                W_IDLE: begin
                    AWREADY <= 1'b1;
                    if (AWVALID && AWREADY) begin
                        wr_addr  <= AWADDR;
                        wr_len   <= AWLEN;
                        wr_burst <= AWBURST;
                        wr_cnt   <= '0;
                        wr_err   <= 1'b0;
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b1;
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        wr_addr <= wr_next;
                        wr_cnt  <= wr_cnt + 8'd1;
                        wr_err  <= wr_err | w_bad;
                        if (w_last) begin
                            WREADY   <= 1'b0;
                            BVALID   <= 1'b1;
                            BRESP    <= (wr_err | w_bad) ? SLVERR : OKAY;
                            wr_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID   <= 1'b0;
                        BRESP    <= OKAY;
                        AWREADY  <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Memory contents survive reset; only the write strobe is gated.
    always_ff @(posedge ACLK) begin
        if (ARESETn && w_fire && !wr_beat_err) begin
            for (int b = 0; b < NB; b++) begin
                if (WSTRB[b]) mem[wr_idx + AW'(b)] <= WDATA[8*b +: 8];
            end
        end
    end

    rd_state_t         rd_state;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic [1:0]        rd_burst;
    logic [7:0]        rd_cnt;
    logic [ADDR_W-1:0] ra_addr;
    logic [7:0]        ra_len;
    logic [1:0]        ra_burst;
    logic [ADDR_W-1:0] rd_next;
    logic              rd_beat_err;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_word;

    // In idle the address unit looks at AR so beat 0 loads on the handshake;
    // afterwards it looks at the registered address of the next beat.
    assign ra_addr  = (rd_state == R_IDLE) ? ARADDR  : rd_addr;
    assign ra_len   = (rd_state == R_IDLE) ? ARLEN   : rd_len;
    assign ra_burst = (rd_state == R_IDLE) ? ARBURST : rd_burst;
    assign rd_idx   = {ra_addr[AW-1:LW], {LW{1'b0}}};

    axi_burst_addr #(.ADDR_W(ADDR_W), .NB(NB), .AW(AW)) u_rd_addr (
        .addr      (ra_addr),
        .len       (ra_len),
        .burst     (ra_burst),
        .next_addr (rd_next),
        .burst_err (rd_beat_err)
    );

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NB; b++) begin
            rd_word[8*b +: 8] = mem[rd_idx + AW'(b)];
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rd_state <= R_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RLAST    <= 1'b0;
            RDATA    <= '0;
            RRESP    <= OKAY;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_burst <= '0;
            rd_cnt   <= '0;
        end else begin
            unique case (rd_state)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        rd_len   <= ARLEN;
                        rd_burst <= ARBURST;
                        rd_cnt   <= '0;
                        rd_addr  <= rd_next;
                        RDATA    <= rd_beat_err ? '0 : rd_word;
                        RRESP    <= rd_beat_err ? SLVERR : OKAY;
                        RLAST    <= (ARLEN == 8'd0);
                        RVALID   <= 1'b1;
                        ARREADY  <= 1'b0;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID   <= 1'b0;
                            RLAST    <= 1'b0;
                            ARREADY  <= 1'b1;
                            rd_state <= R_IDLE;
                        end else begin
                            rd_cnt  <= rd_cnt + 8'd1;
                            rd_addr <= rd_next;
                            RDATA   <= rd_beat_err ? '0 : rd_word;
                            RRESP   <= rd_beat_err ? SLVERR : OKAY;
                            RLAST   <= ((rd_cnt + 8'd1) == rd_len);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_sub_burst_mem.sv
// Self-checking bench for axi4_sub_burst_mem: directed and random bursts
// against a byte-array reference model.
module tb_axi4_sub_burst_mem;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 4096;
    localparam int NB        = DATA_W / 8;
    localparam int TMO       = 100;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [NB-1:0]     WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    always #5 ACLK = ~ACLK;

    axi4_sub_burst_mem #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    logic [7:0]        model [MEM_BYTES];
    logic [DATA_W-1:0] wbuf [256];
    logic [NB-1:0]     sbuf [256];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] start,
        input int len, input int burst, input int i);
        longint unsigned a0, w, base;
        a0 = (longint'(start) / NB) * NB;
        if (i == 0 || burst == 0 || burst == 3) return start;
        if (burst == 1) return 32'(a0 + longint'(i) * NB);
        w = longint'(len + 1) * NB;
        base = (longint'(start) / w) * w;
        return 32'(base + (a0 - base + longint'(i) * NB) % w);
    endfunction

    function automatic bit beat_bad(input logic [31:0] a, input int len,
                                    input int burst);
        bit wrap_ok;
`ifdef SUBMEM_WRAP_EN
        wrap_ok = (len == 1 || len == 3 || len == 7 || len == 15);
`else
        wrap_ok = 1'b0;
`endif
        return (a >= MEM_BYTES) || (burst == 3) || (burst == 2 && !wrap_ok);
    endfunction

    function automatic logic [DATA_W-1:0] model_word(input logic [31:0] a);
        logic [DATA_W-1:0] w;
        int base;
        base = int'(a) / NB * NB;
        for (int b = 0; b < NB; b++) w[8*b +: 8] = model[base + b];
        return w;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_awready"}, 64'(AWREADY), 0);
        check({tag, "_wready"},  64'(WREADY), 0);
        check({tag, "_bvalid"},  64'(BVALID), 0);
        check({tag, "_arready"}, 64'(ARREADY), 0);
        check({tag, "_rvalid"},  64'(RVALID), 0);
        check({tag, "_rlast"},   64'(RLAST), 0);
        check({tag, "_rdata"},   64'(RDATA), 0);
        check({tag, "_bresp"},   64'(BRESP), 0);
        check({tag, "_rresp"},   64'(RRESP), 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len,
        input int burst, input int last_at, input int bstall,
        input int rst_at);
        bit err;
        int t, base;
        logic [31:0] a;
        err = 1'b0;
        @(negedge ACLK);
        AWADDR = addr; AWLEN = 8'(len); AWBURST = 2'(burst); AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < TMO) begin @(negedge ACLK); t++; end
        if (t >= TMO) begin check("aw_timeout", 0, 1); AWVALID = 0; return; end
        @(posedge ACLK); @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, burst, i);
            WDATA = wbuf[i]; WSTRB = sbuf[i];
            WLAST = (i == last_at); WVALID = 1'b1;
            if (i == rst_at) begin
                ARESETn = 1'b0;
                @(posedge ACLK); @(negedge ACLK);
                check_zero_outputs("midrst");
                ARESETn = 1'b1; WVALID = 1'b0; WLAST = 1'b0;
                @(posedge ACLK); @(negedge ACLK);
                check("midrst_awready", 64'(AWREADY), 1);
                check("midrst_arready", 64'(ARREADY), 1);
                check("midrst_bvalid",  64'(BVALID), 0);
                return;
            end
            t = 0;
            while (!WREADY && t < TMO) begin @(negedge ACLK); t++; end
            if (t >= TMO) begin check("w_timeout", 0, 1); WVALID = 0; return; end
            @(posedge ACLK); @(negedge ACLK);
            WVALID = 1'b0; WLAST = 1'b0;
            if (beat_bad(a, len, burst)) err = 1'b1;
            else begin
                base = int'(a) / NB * NB;
                for (int b = 0; b < NB; b++)
                    if (sbuf[i][b]) model[base + b] = wbuf[i][8*b +: 8];
            end
            if ((i == last_at) != (i == len)) err = 1'b1;
        end
        t = 0;
        while (!BVALID && t < TMO) begin @(negedge ACLK); t++; end
        if (t >= TMO) begin check("b_timeout", 0, 1); return; end
        for (int s = 0; s < bstall; s++) begin
            check("b_hold_bvalid", 64'(BVALID), 1);
            check("b_hold_awready", 64'(AWREADY), 0);
            @(negedge ACLK);
        end
        check("bresp", 64'(BRESP), err ? 64'd2 : 64'd0);
        BREADY = 1'b1;
        @(posedge ACLK); @(negedge ACLK);
        BREADY = 1'b0;
        check("b_done_bvalid", 64'(BVALID), 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len,
        input int burst, input int stall_at, input int stall_n);
        int t;
        bit bad;
        logic [31:0] a;
        logic [DATA_W-1:0] exp;
        @(negedge ACLK);
        ARADDR = addr; ARLEN = 8'(len); ARBURST = 2'(burst); ARVALID = 1'b1;
        t = 0;
        while (!ARREADY && t < TMO) begin @(negedge ACLK); t++; end
        if (t >= TMO) begin check("ar_timeout", 0, 1); ARVALID = 0; return; end
        @(posedge ACLK); @(negedge ACLK);
        ARVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!RVALID && t < TMO) begin @(negedge ACLK); t++; end
            if (t >= TMO) begin check("r_timeout", 0, 1); return; end
            a = beat_addr(addr, len, burst, i);
            bad = beat_bad(a, len, burst);
            exp = bad ? '0 : model_word(a);
            check("rdata", 64'(RDATA), 64'(exp));
            check("rresp", 64'(RRESP), bad ? 64'd2 : 64'd0);
            check("rlast", 64'(RLAST), 64'(i == len));
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge ACLK);
                    check("stall_rvalid", 64'(RVALID), 1);
                    check("stall_rdata", 64'(RDATA), 64'(exp));
                    check("stall_rlast", 64'(RLAST), 64'(i == len));
                end
            end
            RREADY = 1'b1;
            @(posedge ACLK); @(negedge ACLK);
            RREADY = 1'b0;
        end
        check("r_done_rvalid", 64'(RVALID), 0);
        check("r_done_arready", 64'(ARREADY), 1);
    endtask

    initial begin
        logic [31:0] ra;
        int rl, rb, la;
        AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        for (int k = 0; k < MEM_BYTES; k++) model[k] = 8'h00;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_zero_outputs("reset");
        ARESETn = 1'b1;
        @(posedge ACLK); @(negedge ACLK);
        check("post_reset_awready", 64'(AWREADY), 1);
        check("post_reset_arready", 64'(ARREADY), 1);

        for (int i = 0; i < 256; i++) begin wbuf[i] = '0; sbuf[i] = '1; end
        for (int k = 0; k < MEM_BYTES / (256 * NB); k++)
            do_write(32'(k * 256 * NB), 255, 1, 255, 0, -1);

        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'h11111111 * 32'(i + 1); sbuf[i] = 4'hF;
        end
        do_write(32'h100, 3, 1, 3, 0, -1);
        do_read(32'h100, 3, 1, -1, 0);

        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        do_write(32'h200, 0, 1, 0, 0, -1);
        check("strobe_model", 64'(model_word(32'h200)), 64'h00BB00DD);
        do_read(32'h200, 0, 1, -1, 0);

        do_read(32'h108, 3, 2, -1, 0);

        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(32'h1000, 0, 1, 0, 0, -1);
        for (int i = 0; i < 3; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        do_write(32'h300, 2, 1, 1, 0, -1);
        do_read(32'h300, 2, 1, -1, 0);
        do_read(32'h000, 0, 1, -1, 0);

        do_read(32'h100, 3, 1, 1, 5);
        wbuf[0] = 32'h5A5A5A5A; sbuf[0] = 4'hF;
        do_write(32'h500, 0, 1, 0, 4, -1);

        for (int i = 0; i < 8; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        do_write(32'h400, 7, 1, 7, 0, 2);
        do_read(32'h400, 7, 1, -1, 0);

        for (int n = 0; n < 40; n++) begin
            ra = 32'($urandom_range(0, MEM_BYTES - 1)) & ~32'(NB - 1);
            if ($urandom_range(0, 7) == 0) ra = ra + 32'(MEM_BYTES);
            rl = $urandom_range(0, 15);
            rb = $urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2);
            la = $urandom_range(0, 7) == 0 ? $urandom_range(0, rl) : rl;
            for (int i = 0; i <= rl; i++) begin
                wbuf[i] = $urandom; sbuf[i] = 4'($urandom);
            end
            if ($urandom_range(0, 1) == 0)
                do_write(ra, rl, rb, la, $urandom_range(0, 2), -1);
            else
                do_read(ra, rl, rb, $urandom_range(0, rl), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi4_sub_burst_mem.md
Name: axi4_sub_burst_mem

Overview:
- Parametrised AXI4 subordinate with internal byte-addressed memory.
- Supports multi-beat FIXED, INCR and WRAP bursts, WSTRB byte enables, and SLVERR on bad accesses.
- Read and write paths are independent.
- Sits as a leaf target behind the interconnect and is the standard memory model for manager-side benches.

Parameters:
DATA_W, 32, data bus width in bits; power of 2, 32 to 128; NB = DATA_W/8 bytes per beat
ADDR_W, 32, address bus width in bits
MEM_BYTES, 4096, memory size in bytes; power of 2; AW = log2(MEM_BYTES)

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset, synchronous, active-low
AWADDR  in  ADDR_W  write burst start address
AWLEN  in  8  write beats minus 1
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID / AWREADY  in / out  1  AW handshake
WDATA  in  DATA_W  write data
WSTRB  in  NB  byte enables
WLAST  in  1  last write beat
WVALID / WREADY  in / out  1  W handshake
BRESP  out  2  write response
BVALID / BREADY  out / in  1  B handshake
ARADDR  in  ADDR_W  read burst start address
ARLEN  in  8  read beats minus 1
ARBURST  in  2  read burst type
ARVALID / ARREADY  in / out  1  AR handshake
RDATA  out  DATA_W  read data
RRESP  out  2  read response
RLAST  out  1  last read beat
RVALID / RREADY  out / in  1  R handshake

Behaviour:
- Reset: while ARESETn=0 at a rising edge, the following are all 0:
  - AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, RDATA
  - BRESP and RRESP = OKAY
  - both FSMs go to IDLE; memory is not cleared
- First cycle after reset: AWREADY=1, ARREADY=1.
- Reset mid-burst: bytes already written stay in memory; no B or R response is issued for the aborted burst.
- Beat address: all beats are full width (NB bytes).
  - First beat uses AxADDR as given.
  - FIXED: address never changes.
  - INCR: next = (addr & ~(NB-1)) + NB, modulo 2^ADDR_W.
  - WRAP: boundary W = (LEN+1)*NB; next = (addr & ~(W-1)) | ((aligned_addr+NB) & (W-1)).
  - WRAP is only legal for LEN in {1,3,7,15}; any other LEN is an error burst.
- Beat error conditions (any one makes the beat an error):
  - any address bit at or above AW is set
  - AxBURST = 11
  - illegal WRAP LEN
  - WRAP used with SUBMEM_WRAP_EN undefined
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1; on AW handshake latch addr/len/burst, clear beat count and error flag.
  - W_DATA: WREADY=1, AWREADY=0. Each W handshake writes the bytes with WSTRB set, only if the beat is not in error.
  - Burst ends on the beat where count == LEN; WLAST is never used for termination.
  - WLAST != (count == LEN) on any beat sets the error flag.
  - W_RESP: BVALID=1; BRESP = SLVERR if any beat erred, else OKAY. BVALID holds until BREADY, then return to W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - AR handshake at edge N gives RVALID=1 with beat 0 from edge N+1; ARREADY=0 while in R_DATA.
  - RDATA, RRESP and RLAST are registers, stable while RVALID=1 and RREADY=0.
  - On each R handshake the next beat loads the following cycle, so sustained rate is 1 beat per cycle.
  - RLAST=1 on the beat where count == LEN; that handshake returns to R_IDLE.
  - Error beat: RDATA=0, RRESP=SLVERR; the burst still runs its full LEN+1 beats.
- Same-edge read and write to one byte: read is loaded before the write (read-before-write).

Optional Feature:
- SUBMEM_WRAP_EN defined: WRAP bursts are fully supported as above.
- SUBMEM_WRAP_EN undefined:
  - WRAP bursts complete with the full handshake, but every beat is an error.
  - No memory write; BRESP = SLVERR; RRESP = SLVERR with RDATA=0.
  - The wrap address logic is not synthesised.

Decomposition:
- Shared package axi_helper:
  - resp_t (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11)
  - new burst_t (FIXED, INCR, WRAP, RSVD)
  - new wr_state_t and rd_state_t
- Sub-module axi_burst_addr, instantiated once for write and once for read:
  - inputs: addr, len, burst
  - outputs: next_addr, burst_err
  - purely combinational next-address and legality check
- Memory array and both FSMs stay in axi4_sub_burst_mem.

Test Plan:
- INCR write AWADDR=0x100, AWLEN=3, WDATA=0x11111111..0x44444444, WSTRB=F, WLAST on beat 3 -> BRESP=OKAY; then INCR read 0x100 len 3 returns the same 4 words, RLAST only on beat 3, RRESP=OKAY.
- Write 0x200 data 0xAABBCCDD WSTRB=0101 over prior 0x00000000 -> read 0x200 returns 0x00BB00DD.
- WRAP read ARADDR=0x108, ARLEN=3, NB=4 -> beat addresses 0x108, 0x10C, 0x100, 0x104. With SUBMEM_WRAP_EN undefined -> 4 beats, RDATA=0, RRESP=SLVERR.
- Write AWADDR=0x1000 (MEM_BYTES=4096) len 0 -> memory unchanged, BRESP=SLVERR. Separately, WLAST asserted on beat 1 of AWLEN=2 -> 3 beats accepted, BRESP=SLVERR.
- Hold RREADY=0 for 5 cycles mid-burst -> RDATA/RLAST stable and RVALID held. Hold BREADY=0 -> BVALID held, AWREADY=0 until B handshake.
- ARESETn=0 for 1 cycle during beat 2 of an AWLEN=7 write -> all outputs 0 that cycle; next cycle AWREADY=ARREADY=1, no BVALID; beats 0-1 stay in memory.
